// File: rtl/writeback_buffer.sv
// Writeback buffer: collects results from two producers into a small circular
// FIFO and drains them onto two register-file write ports, issuing two entries
// per cycle unless the two oldest entries target the same destination register.
module writeback_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             iClock,
    input  logic             iReset_n,
    input  logic             iValid1,
    input  logic [20:0]      iResult1,
    output logic             oReady1,
    input  logic             iValid2,
    input  logic [20:0]      iResult2,
    output logic             oReady2,
    input  logic             iHold,
    output logic             oWritePort1,
    output logic [20:0]      oRegWrite1,
    output logic             oWritePort2,
    output logic [20:0]      oRegWrite2,
    output logic [CNT_W-1:0] oCount,
    output logic             oEmpty
);

    localparam int PTR_W = $clog2(DEPTH);

    // Ready thresholds in count width so the compares carry no width mismatch.
    localparam logic [CNT_W-1:0] LIMIT1 = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] LIMIT2 = CNT_W'(DEPTH - 2);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic [20:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] wr2_idx;
    logic [PTR_W-1:0] rd2_idx;
    logic [CNT_W-1:0] count_q, count_d;

    logic             wp1_q, wp2_q;
    logic [20:0]      rw1_q, rw2_q;

    logic             push1, push2;
    logic [1:0]       enq_cnt;
    logic [1:0]       issue_cnt;
    logic [20:0]      head_entry, second_entry;

    // Ready is decoded from the registered count alone, so a full FIFO can
    // never see an enqueue and a pop on the same edge.
    assign oReady1 = (count_q <= LIMIT1);
    assign oReady2 = (count_q <= LIMIT2);

    assign push1   = iValid1 & oReady1;
    assign push2   = iValid2 & oReady2;
    assign enq_cnt = {1'b0, push1} + {1'b0, push2};

    // Port 2 lands one slot behind port 1 when both transfer together.
    assign wr2_idx = wr_ptr_q + PTR_W'(push1);
    assign rd2_idx = rd_ptr_q + PTR_W'(1);

    assign head_entry   = mem_q[rd_ptr_q];
    assign second_entry = mem_q[rd2_idx];

    // Decide how many of the oldest entries leave this cycle.
    always_comb begin
        issue_cnt = 2'd0;
        if (!iHold && (count_q != '0)) begin
            if (count_q == ONE) begin
                issue_cnt = 2'd1;
            end else if (head_entry[20:16] != second_entry[20:16]) begin
                issue_cnt = 2'd2;
            end else begin
                issue_cnt = 2'd1;
            end
        end
    end

    // Next-state pointers and occupancy; power-of-two depth makes wrap free.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(enq_cnt);
        rd_ptr_d = rd_ptr_q + PTR_W'(issue_cnt);
        count_d  = count_q + CNT_W'(enq_cnt) - CNT_W'(issue_cnt);
    end

    // Storage array: written only into free slots, so it needs no reset.
    always_ff @(posedge iClock) begin
        if (push1) begin
            mem_q[wr_ptr_q] <= iResult1;
        end
        if (push2) begin
            mem_q[wr2_idx] <= iResult2;
        end
    end

    // Pointer and count registers; reset drops every buffered entry.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Registered write ports: enables pulse per issued entry, payloads of
    // unused ports keep their last value.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            wp1_q <= 1'b0;
            wp2_q <= 1'b0;
            rw1_q <= 21'h0;
            rw2_q <= 21'h0;
        end else begin
            wp1_q <= (issue_cnt != 2'd0);
            wp2_q <= (issue_cnt == 2'd2);
            if (issue_cnt != 2'd0) begin
                rw1_q <= head_entry;
            end
            if (issue_cnt == 2'd2) begin
                rw2_q <= second_entry;
            end
        end
    end

    assign oWritePort1 = wp1_q;
    assign oWritePort2 = wp2_q;
    assign oRegWrite1  = rw1_q;
    assign oRegWrite2  = rw2_q;
    assign oCount      = count_q;
    assign oEmpty      = (count_q == '0);

endmodule

// File: tb/tb_writeback_buffer.sv
// Directed bench for writeback_buffer: a vector table for single-cycle
// behaviour plus hand-written full/wrap and mid-stream reset sequences.
module tb_writeback_buffer;

    logic        clk;
    logic        rst_n;
    logic        v1, v2, hold;
    logic [20:0] r1, r2;
    logic        rdy1, rdy2;
    logic        wp1, wp2;
    logic [20:0] rw1, rw2;
    logic [2:0]  cnt;
    logic        empty;

    int errors = 0;
    int checks = 0;

    writeback_buffer #(.DEPTH(4), .CNT_W(3)) dut (
        .iClock      (clk),
        .iReset_n    (rst_n),
        .iValid1     (v1),
        .iResult1    (r1),
        .oReady1     (rdy1),
        .iValid2     (v2),
        .iResult2    (r2),
        .oReady2     (rdy2),
        .iHold       (hold),
        .oWritePort1 (wp1),
        .oRegWrite1  (rw1),
        .oWritePort2 (wp2),
        .oRegWrite2  (rw2),
        .oCount      (cnt),
        .oEmpty      (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v1;
        logic [20:0] r1;
        logic        v2;
        logic [20:0] r2;
        logic        hold;
        logic        e_wp1;
        logic [20:0] e_rw1;
        logic        e_wp2;
        logic [20:0] e_rw2;
        logic [2:0]  e_cnt;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic a_v1, input logic [20:0] a_r1,
                                input logic a_v2, input logic [20:0] a_r2,
                                input logic a_hold,
                                input logic a_wp1, input logic [20:0] a_rw1,
                                input logic a_wp2, input logic [20:0] a_rw2,
                                input logic [2:0] a_cnt);
        vec_t t;
        t.v1 = a_v1; t.r1 = a_r1; t.v2 = a_v2; t.r2 = a_r2; t.hold = a_hold;
        t.e_wp1 = a_wp1; t.e_rw1 = a_rw1; t.e_wp2 = a_wp2; t.e_rw2 = a_rw2;
        t.e_cnt = a_cnt;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic e_wp1, input logic [20:0] e_rw1,
                            input logic e_wp2, input logic [20:0] e_rw2, input logic [2:0] e_cnt);
        chk({tag, ".wp1"},   32'(wp1),   32'(e_wp1));
        chk({tag, ".rw1"},   32'(rw1),   32'(e_rw1));
        chk({tag, ".wp2"},   32'(wp2),   32'(e_wp2));
        chk({tag, ".rw2"},   32'(rw2),   32'(e_rw2));
        chk({tag, ".cnt"},   32'(cnt),   32'(e_cnt));
        chk({tag, ".empty"}, 32'(empty), 32'(e_cnt == 3'd0));
    endtask

    initial begin
        logic [20:0] e [4];
        logic [20:0] junk;
        int          wr_seen;

        junk = 21'h1FDEAD;

        // idx: v1 r1 v2 r2 hold | wp1 rw1 wp2 rw2 cnt
        vecs[0]  = mk(1, 21'h03ABCD, 0, 21'h0,     0, 0, 21'h000000, 0, 21'h000000, 1);
        vecs[1]  = mk(0, 21'h0,      0, 21'h0,     0, 1, 21'h03ABCD, 0, 21'h000000, 0);
        vecs[2]  = mk(0, 21'h0,      0, 21'h0,     0, 0, 21'h03ABCD, 0, 21'h000000, 0);
        vecs[3]  = mk(1, 21'h011111, 1, 21'h022222,0, 0, 21'h03ABCD, 0, 21'h000000, 2);
        vecs[4]  = mk(0, 21'h0,      0, 21'h0,     0, 1, 21'h011111, 1, 21'h022222, 0);
        vecs[5]  = mk(1, 21'h070001, 1, 21'h070002,0, 0, 21'h011111, 0, 21'h022222, 2);
        vecs[6]  = mk(0, 21'h0,      0, 21'h0,     0, 1, 21'h070001, 0, 21'h022222, 1);
        vecs[7]  = mk(0, 21'h0,      0, 21'h0,     0, 1, 21'h070002, 0, 21'h022222, 0);
        vecs[8]  = mk(0, 21'h0,      0, 21'h0,     0, 0, 21'h070002, 0, 21'h022222, 0);
        vecs[9]  = mk(1, 21'h0A0005, 0, 21'h0,     1, 0, 21'h070002, 0, 21'h022222, 1);
        vecs[10] = mk(0, 21'h0,      0, 21'h0,     1, 0, 21'h070002, 0, 21'h022222, 1);
        vecs[11] = mk(0, 21'h0,      1, 21'h0B0006,0, 1, 21'h0A0005, 0, 21'h022222, 1);
        vecs[12] = mk(0, 21'h0,      0, 21'h0,     0, 1, 21'h0B0006, 0, 21'h022222, 0);
        vecs[13] = mk(1, 21'h000077, 1, 21'h000088,0, 0, 21'h0B0006, 0, 21'h022222, 2);
        vecs[14] = mk(0, 21'h0,      0, 21'h0,     0, 1, 21'h000077, 0, 21'h022222, 1);
        vecs[15] = mk(0, 21'h0,      0, 21'h0,     0, 1, 21'h000088, 0, 21'h022222, 0);
        vecs[16] = mk(1, 21'h0C0001, 1, 21'h0D0002,0, 0, 21'h000088, 0, 21'h022222, 2);
        vecs[17] = mk(1, 21'h0E0003, 0, 21'h0,     0, 1, 21'h0C0001, 1, 21'h0D0002, 1);
        vecs[18] = mk(0, 21'h0,      0, 21'h0,     1, 0, 21'h0C0001, 0, 21'h0D0002, 1);
        vecs[19] = mk(0, 21'h0,      0, 21'h0,     0, 1, 21'h0E0003, 0, 21'h0D0002, 0);
        vecs[20] = mk(1, 21'h0F0004, 0, 21'h0,     0, 0, 21'h0E0003, 0, 21'h0D0002, 1);
        vecs[21] = mk(0, 21'h0,      0, 21'h0,     0, 1, 21'h0F0004, 0, 21'h0D0002, 0);

        // Reset state
        rst_n = 1'b0; v1 = 0; v2 = 0; r1 = '0; r2 = '0; hold = 0;
        #12;
        chk_outs("reset", 0, 21'h0, 0, 21'h0, 3'd0);
        chk("reset.rdy1", 32'(rdy1), 32'd1);
        chk("reset.rdy2", 32'(rdy2), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Table-driven vectors
        for (int i = 0; i < NVEC; i++) begin
            v1 = vecs[i].v1; r1 = vecs[i].r1;
            v2 = vecs[i].v2; r2 = vecs[i].r2;
            hold = vecs[i].hold;
            step();
            $display("vec %0d: wp1=%b rw1=%h wp2=%b rw2=%h cnt=%0d", i, wp1, rw1, wp2, rw2, cnt);
            chk_outs($sformatf("vec%0d", i), vecs[i].e_wp1, vecs[i].e_rw1,
                     vecs[i].e_wp2, vecs[i].e_rw2, vecs[i].e_cnt);
            chk($sformatf("vec%0d.rdy1", i), 32'(rdy1), 32'd1);
            chk($sformatf("vec%0d.rdy2", i), 32'(rdy2), 32'd1);
        end
        v1 = 0; v2 = 0; hold = 0;

        // Fill to full under hold, then drain; three rounds cross the pointer wrap
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 4; j++) begin
                e[j] = {5'(4 * k + j + 1), 16'(k * 256 + j + 16'h0100)};
            end
            hold = 1; v1 = 1; r1 = e[0]; v2 = 0;
            step();
            chk($sformatf("full%0d.cnt1", k), 32'(cnt), 32'd1);
            chk($sformatf("full%0d.wp1a", k), 32'(wp1), 32'd0);
            v1 = 1; r1 = e[1]; v2 = 1; r2 = e[2];
            step();
            chk($sformatf("full%0d.cnt3", k), 32'(cnt), 32'd3);
            chk($sformatf("full%0d.rdy1_3", k), 32'(rdy1), 32'd1);
            chk($sformatf("full%0d.rdy2_3", k), 32'(rdy2), 32'd0);
            v1 = 1; r1 = e[3]; v2 = 1; r2 = junk;
            step();
            chk($sformatf("full%0d.cnt4", k), 32'(cnt), 32'd4);
            chk($sformatf("full%0d.rdy1_4", k), 32'(rdy1), 32'd0);
            chk($sformatf("full%0d.rdy2_4", k), 32'(rdy2), 32'd0);
            r1 = junk;
            step();
            chk($sformatf("full%0d.cnt4b", k), 32'(cnt), 32'd4);
            chk($sformatf("full%0d.wp1b", k), 32'(wp1), 32'd0);
            v1 = 0; v2 = 0; hold = 0;
            step();
            $display("drain %0d a: wp1=%b rw1=%h wp2=%b rw2=%h cnt=%0d", k, wp1, rw1, wp2, rw2, cnt);
            chk_outs($sformatf("drain%0da", k), 1, e[0], 1, e[1], 3'd2);
            step();
            $display("drain %0d b: wp1=%b rw1=%h wp2=%b rw2=%h cnt=%0d", k, wp1, rw1, wp2, rw2, cnt);
            chk_outs($sformatf("drain%0db", k), 1, e[2], 1, e[3], 3'd0);
            step();
            chk_outs($sformatf("drain%0dc", k), 0, e[2], 0, e[3], 3'd0);
        end

        // Reset mid-stream with three entries buffered
        hold = 1; v1 = 1; r1 = 21'h150011; v2 = 0;
        step();
        v1 = 1; r1 = 21'h160022; v2 = 1; r2 = 21'h170033;
        step();
        v1 = 0; v2 = 0;
        chk("rstmid.cnt3", 32'(cnt), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset: wp1=%b rw1=%h wp2=%b rw2=%h cnt=%0d", wp1, rw1, wp2, rw2, cnt);
        chk_outs("rstmid.async", 0, 21'h0, 0, 21'h0, 3'd0);
        step();
        #2;
        rst_n = 1'b1;
        hold = 0;
        wr_seen = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (wp1 || wp2) wr_seen++;
        end
        chk("rstmid.no_write", 32'(wr_seen), 32'd0);
        chk("rstmid.cnt_after", 32'(cnt), 32'd0);

        // Normal operation after reset
        v1 = 1; r1 = 21'h1F1234;
        step();
        v1 = 0;
        chk("post.cnt1", 32'(cnt), 32'd1);
        step();
        $display("post reset write: wp1=%b rw1=%h", wp1, rw1);
        chk_outs("post", 1, 21'h1F1234, 0, 21'h0, 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/writeback_buffer.md
WRITEBACK_BUFFER -- requirements
Module: writeback_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the FIFO entry count; legal values are powers of two, 4 or more.
REQ-002 The block SHALL have parameter CNT_W, default 3, giving the width of oCount; it SHALL equal log2(DEPTH)+1.
REQ-003 iClock  in  1  the single clock; all state changes on its rising edge.
REQ-004 iReset_n  in  1  reset; asynchronous and active-low.
REQ-005 iValid1  in  1  producer 1 offers a result.
REQ-006 iResult1  in  21  producer 1 payload: [20:16] destination register, [15:0] data.
REQ-007 oReady1  out  1  buffer can accept from producer 1.
REQ-008 iValid2  in  1  producer 2 offers a result.
REQ-009 iResult2  in  21  producer 2 payload, same format as iResult1.
REQ-010 oReady2  out  1  buffer can accept from producer 2.
REQ-011 iHold  in  1  register-file write side frozen; no issue this cycle.
REQ-012 oWritePort1  out  1  write enable for register-file write port 1.
REQ-013 oRegWrite1  out  21  write payload for port 1.
REQ-014 oWritePort2  out  1  write enable for register-file write port 2.
REQ-015 oRegWrite2  out  21  write payload for port 2.
REQ-016 oCount  out  CNT_W  number of occupied FIFO entries.
REQ-017 oEmpty  out  1  high when oCount == 0.

Function
REQ-018 A transfer SHALL occur on a port in any cycle where its valid and ready are both high at the rising edge.
REQ-019 oReady1 SHALL be high when oCount <= DEPTH-1, and oReady2 SHALL be high when oCount <= DEPTH-2; both are decoded from the registered count only, with no same-cycle pop credit.
REQ-020 When both ports transfer in the same cycle, iResult1 SHALL be enqueued ahead of iResult2.
REQ-021 The FIFO SHALL use circular read and write pointers that wrap from DEPTH-1 to 0 without loss or duplication.
REQ-022 Issue rules, evaluated each cycle from the FIFO state before that edge's enqueue:
- iHold high or FIFO empty: issue 0 entries.
- Exactly 1 entry: issue 1 entry.
- 2 or more entries, and the two oldest have different destinations: issue 2 entries.
- 2 or more entries, and the two oldest have the same destination: issue 1 entry (the oldest).
REQ-023 Issued entries SHALL be popped at that edge and registered onto the outputs at the same edge: the oldest entry on port 1 and the second-oldest on port 2. Write enables for unused ports SHALL be 0 and their payloads SHALL hold their previous value.
REQ-024 Latency SHALL be 2 edges: a result accepted at edge N into an empty, unheld buffer appears on oWritePort1/oRegWrite1 after edge N+1.
REQ-025 Each write-enable output SHALL be high for exactly one cycle per issued entry.
REQ-026 When iHold is high, the write enables SHALL drop to 0 at the next edge. Enqueue SHALL continue while iHold is high.
REQ-027 oCount SHALL update every edge as oCount + enqueued − issued, and SHALL never exceed DEPTH or go negative.
REQ-028 Same-edge enqueue and pop on a full FIFO SHALL be impossible by construction, because ready depends only on the registered count.
REQ-029 Destination register 0 SHALL be treated like any other destination; it is not filtered.

Reset
REQ-030 While iReset_n is low, the pointers and oCount SHALL be 0, oEmpty SHALL be 1, the write enables SHALL be 0, and the payload outputs SHALL be 21'h0, all asynchronously.
REQ-031 Reset asserted mid-operation SHALL discard all buffered entries with no write issued.
REQ-032 After reset deasserts, the block SHALL operate normally from the first rising edge.

Verification
REQ-033 Single write: one-cycle iValid1 with iResult1={5'd3,16'hABCD} into an empty buffer -> oWritePort1=1 and oRegWrite1=21'h03ABCD for exactly one cycle, 2 edges after acceptance; oWritePort2 stays 0.
REQ-034 Dual write, distinct destinations: same-cycle {5'd1,16'h1111} on port 1 and {5'd2,16'h2222} on port 2 -> both ports write in the same cycle, port 1 carrying reg 1 and port 2 carrying reg 2.
REQ-035 Same destination: same-cycle {5'd7,16'h0001} on port 1 and {5'd7,16'h0002} on port 2 -> reg 7 / 0001 issued alone on port 1, then reg 7 / 0002 on port 1 the next cycle.
REQ-036 Full and wrap: hold iHold=1 and offer continuously on both ports -> oCount reaches 4, oReady1=0 and oReady2=0 at count 4, and oReady2=0 at count 3. Release iHold -> the 4 entries drain in order over 2 cycles; repeat 3 times to exercise pointer wrap.
REQ-037 Reset mid-stream: pulse iReset_n low with 3 entries buffered -> outputs clear immediately without waiting for a clock edge, oCount=0, and no write for those entries ever appears.
